// File: rtl/pingpong_ctrl_pkg.sv
// Shared state encodings and constants for the ping-pong dataflow controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pingpong_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } top_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY
    } stage_state_t;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pingpong_stage_seq.sv
// One process stage: issues ap_start when the channel gate allows, strobes the channel on done.
// Latency: start 1 cycle after gate seen in S_IDLE; channel strobe combinational in the done cycle.
// Backpressure: holds in S_IDLE while gate is low; PINGPONG_CTRL_STALL_CNT_EN counts those cycles.
module pingpong_stage_seq
    import pingpong_ctrl_pkg::*;
#(
    parameter int IterWidth = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clr,
    input  logic [IterWidth-1:0] limit,
    input  logic                 gate,
    output logic                 proc_start,
    input  logic                 proc_ready,
    input  logic                 proc_done,
    output logic                 accept,
    output logic                 fire,
    output logic [IterWidth-1:0] cnt
`ifdef PINGPONG_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    stage_state_t state;
    logic         pending;

    assign pending    = (cnt < limit);
    assign proc_start = (state == S_START);
    assign accept     = (state == S_START) && proc_ready;
    // Ready and done together in S_START count as a completed buffer.
    assign fire       = ((state == S_BUSY) && proc_done) || (accept && proc_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + IterWidth'(1);
            end
            case (state)
                S_IDLE:  if (run && pending && gate) state <= S_START;
                S_START: if (proc_ready) state <= proc_done ? S_IDLE : S_BUSY;
                S_BUSY:  if (proc_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PINGPONG_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (run && pending && (state == S_IDLE) && !gate && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

    // The gate was checked before starting and only this stage consumes it.
    assert property (@(posedge clk) disable iff (!reset) fire |-> gate);

endmodule

// File: rtl/pingpong_dataflow_ctrl.sv
// Top FSM: runs num_iter producer/consumer iterations over a ping-pong channel per ap_start.
// Latency: ap_done/ap_ready registered, 1 cycle after final pop / last producer accept.
// Backpressure: stages gated by chan_i_full_n/chan_t_empty_n; PINGPONG_CTRL_STALL_CNT_EN adds stall counters.
module pingpong_dataflow_ctrl
    import pingpong_ctrl_pkg::*;
#(
    parameter int BufferCount = 2,
    parameter int IterWidth   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic                 ap_ready,
    input  logic [IterWidth-1:0] num_iter,
    output logic                 prod_ap_start,
    input  logic                 prod_ap_ready,
    input  logic                 prod_ap_done,
    output logic                 cons_ap_start,
    input  logic                 cons_ap_ready,
    input  logic                 cons_ap_done,
    output logic                 chan_i_ce,
    output logic                 chan_i_write,
    input  logic                 chan_i_full_n,
    output logic                 chan_t_ce,
    output logic                 chan_t_read,
    input  logic                 chan_t_empty_n
`ifdef PINGPONG_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] prod_stall_cnt,
    output logic [STALL_CNT_W-1:0] cons_stall_cnt
`endif
);

    top_state_t           state;
    logic [IterWidth-1:0] n_iter;
    logic                 run;
    logic                 clr;
    logic                 prod_accept;
    logic                 prod_fire;
    logic [IterWidth-1:0] p_cnt;
    logic                 cons_accept;
    logic                 cons_fire;
    logic [IterWidth-1:0] c_cnt;

    assign run     = (state == RUN);
    assign clr     = (state == IDLE) && ap_start;
    assign ap_idle = (state == IDLE);

    assign chan_i_ce    = prod_fire;
    assign chan_i_write = prod_fire;
    assign chan_t_ce    = cons_fire;
    assign chan_t_read  = cons_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n_iter   <= '0;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        n_iter <= num_iter;
                        if (num_iter == '0) begin
                            ap_done  <= 1'b1;
                            ap_ready <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (prod_accept && (p_cnt == n_iter - IterWidth'(1))) begin
                        ap_ready <= 1'b1;
                    end
                    // Finish on the pop that completes the Nth consumer iteration.
                    if (cons_fire && ((c_cnt + IterWidth'(cons_accept)) == n_iter)) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    pingpong_stage_seq #(
        .IterWidth (IterWidth)
    ) u_prod (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clr        (clr),
        .limit      (n_iter),
        .gate       (chan_i_full_n),
        .proc_start (prod_ap_start),
        .proc_ready (prod_ap_ready),
        .proc_done  (prod_ap_done),
        .accept     (prod_accept),
        .fire       (prod_fire),
        .cnt        (p_cnt)
`ifdef PINGPONG_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (prod_stall_cnt)
`endif
    );

    pingpong_stage_seq #(
        .IterWidth (IterWidth)
    ) u_cons (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clr        (clr),
        .limit      (n_iter),
        .gate       (chan_t_empty_n),
        .proc_start (cons_ap_start),
        .proc_ready (cons_ap_ready),
        .proc_done  (cons_ap_done),
        .accept     (cons_accept),
        .fire       (cons_fire),
        .cnt        (c_cnt)
`ifdef PINGPONG_CTRL_STALL_CNT_EN
        ,
        .stall_cnt  (cons_stall_cnt)
`endif
    );

    // Producer can lead by every channel buffer plus the one it is filling.
    assert property (@(posedge clk) disable iff (!reset)
        (p_cnt - c_cnt) <= IterWidth'(BufferCount + 1));

endmodule

// File: tb/tb_pingpong_dataflow_ctrl.sv
// Directed bench: process/channel models driven #1 after posedge, DUT sampled on negedge.
module tb_pingpong_dataflow_ctrl;

    localparam int IW   = 16;
    localparam int BUFS = 2;

    logic          clk            = 1'b0;
    logic          reset          = 1'b1;
    logic          ap_start       = 1'b0;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [IW-1:0] num_iter       = '0;
    logic          prod_ap_start;
    logic          prod_ap_ready  = 1'b0;
    logic          prod_ap_done   = 1'b0;
    logic          cons_ap_start;
    logic          cons_ap_ready  = 1'b0;
    logic          cons_ap_done   = 1'b0;
    logic          chan_i_ce;
    logic          chan_i_write;
    logic          chan_i_full_n  = 1'b1;
    logic          chan_t_ce;
    logic          chan_t_read;
    logic          chan_t_empty_n = 1'b0;
`ifdef PINGPONG_CTRL_STALL_CNT_EN
    logic [31:0]   prod_stall_cnt;
    logic [31:0]   cons_stall_cnt;
`endif

    pingpong_dataflow_ctrl #(
        .BufferCount (BUFS),
        .IterWidth   (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .num_iter       (num_iter),
        .prod_ap_start  (prod_ap_start),
        .prod_ap_ready  (prod_ap_ready),
        .prod_ap_done   (prod_ap_done),
        .cons_ap_start  (cons_ap_start),
        .cons_ap_ready  (cons_ap_ready),
        .cons_ap_done   (cons_ap_done),
        .chan_i_ce      (chan_i_ce),
        .chan_i_write   (chan_i_write),
        .chan_i_full_n  (chan_i_full_n),
        .chan_t_ce      (chan_t_ce),
        .chan_t_read    (chan_t_read),
        .chan_t_empty_n (chan_t_empty_n)
`ifdef PINGPONG_CTRL_STALL_CNT_EN
        ,
        .prod_stall_cnt (prod_stall_cnt),
        .cons_stall_cnt (cons_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {ap_done, ap_ready, prod_ap_start, cons_ap_start,
                chan_i_ce, chan_i_write, chan_t_ce, chan_t_read};
    endfunction

    // Model delays, written only by the main sequence.
    int p_rd = 0, p_dd = 0, c_rd = 0, c_dd = 0;
    int epoch = 0;

    // Per-run statistics and model state, written only by the model block.
    int cyc = 0, m_epoch = -1;
    int e_push, e_pop, e_done, e_ready, e_prdy, prdy_at_ready;
    int ready_cyc, done_cyc, last_pop_cyc, last_push_cyc, last_prdy_cyc, st_cyc;
    int max_occ, viol, e_pstart, e_cstart, e_full, gap_min, gap_max;
    bit have_push, prev_pstart, prev_cstart, prev_full, prev_empty;
    int occ = 0, pph = 0, pc = 0, cph = 0, cc = 0;
    logic np_rdy, np_done, nc_rdy, nc_done;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            np_rdy = 1'b0; np_done = 1'b0; nc_rdy = 1'b0; nc_done = 1'b0;
            if (epoch != m_epoch) begin
                m_epoch = epoch;
                e_push = 0; e_pop = 0; e_done = 0; e_ready = 0; e_prdy = 0; prdy_at_ready = 0;
                ready_cyc = 0; done_cyc = 0; last_pop_cyc = 0; last_push_cyc = 0;
                last_prdy_cyc = 0; st_cyc = 0; max_occ = occ; viol = 0;
                e_pstart = 0; e_cstart = 0; e_full = 0; gap_min = 1000; gap_max = 0;
                have_push = 1'b0;
            end
            if (!reset) begin
                occ = 0; pph = 0; cph = 0;
                prev_pstart = 1'b0; prev_cstart = 1'b0; prev_full = 1'b1; prev_empty = 1'b0;
            end else begin
                if (ap_start && ap_idle) st_cyc = cyc;
                if (prod_ap_start) begin
                    e_pstart++;
                    if (!prev_pstart) begin
                        if (!prev_full) viol++;
                        if (have_push) begin
                            if (cyc - last_push_cyc < gap_min) gap_min = cyc - last_push_cyc;
                            if (cyc - last_push_cyc > gap_max) gap_max = cyc - last_push_cyc;
                        end
                    end
                end
                if (cons_ap_start) begin
                    e_cstart++;
                    if (!prev_cstart && !prev_empty) viol++;
                end
                if (prod_ap_start && prod_ap_ready) begin e_prdy++; last_prdy_cyc = cyc; end
                if (chan_i_write) begin
                    e_push++; last_push_cyc = cyc; have_push = 1'b1;
                    if (!chan_i_full_n || !chan_i_ce) viol++;
                end
                if (chan_t_read) begin
                    e_pop++; last_pop_cyc = cyc;
                    if (!chan_t_empty_n || !chan_t_ce) viol++;
                end
                if (ap_ready) begin e_ready++; ready_cyc = cyc; prdy_at_ready = e_prdy; end
                if (ap_done) begin e_done++; done_cyc = cyc; end
                if (!chan_i_full_n) e_full++;
                occ = occ + int'(chan_i_write) - int'(chan_t_read);
                if (occ > max_occ) max_occ = occ;
                prev_pstart = prod_ap_start; prev_cstart = cons_ap_start;
                prev_full = chan_i_full_n; prev_empty = chan_t_empty_n;

                if (pph == 0 && prod_ap_start && !prod_ap_ready) begin pph = 1; pc = p_rd; end
                if (pph == 1) begin
                    if (pc == 0) begin
                        np_rdy = 1'b1;
                        if (p_dd == 0) begin np_done = 1'b1; pph = 0; end
                        else begin pph = 2; pc = p_dd; end
                    end else pc--;
                end else if (pph == 2) begin
                    pc--;
                    if (pc == 0) begin np_done = 1'b1; pph = 0; end
                end

                if (cph == 0 && cons_ap_start && !cons_ap_ready) begin cph = 1; cc = c_rd; end
                if (cph == 1) begin
                    if (cc == 0) begin
                        nc_rdy = 1'b1;
                        if (c_dd == 0) begin nc_done = 1'b1; cph = 0; end
                        else begin cph = 2; cc = c_dd; end
                    end else cc--;
                end else if (cph == 2) begin
                    cc--;
                    if (cc == 0) begin nc_done = 1'b1; cph = 0; end
                end
            end
            @(posedge clk);
            #1;
            prod_ap_ready  = np_rdy;
            prod_ap_done   = np_done;
            cons_ap_ready  = nc_rdy;
            cons_ap_done   = nc_done;
            chan_i_full_n  = (occ < BUFS);
            chan_t_empty_n = (occ > 0);
        end
    end

    task automatic launch(input int n, input int pr, input int pd, input int cr, input int cd);
        p_rd = pr; p_dd = pd; c_rd = cr; c_dd = cd;
        @(posedge clk); #2;
        epoch++;
        ap_start = 1'b1;
        num_iter = IW'(n);
        @(posedge clk); #2;
        ap_start = 1'b0;
    endtask

    task automatic do_run(input int n, input int pr, input int pd, input int cr, input int cd,
                          input int budget, input bit stray);
        int k;
        launch(n, pr, pd, cr, cd);
        k = 0;
        while (e_done == 0 && k < budget) begin
            @(posedge clk); #2;
            k++;
            if (stray && k == 4) begin ap_start = 1'b1; num_iter = '0; end
            else ap_start = 1'b0;
        end
        ap_start = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
    endtask

    initial begin
        int k;
        #2 reset = 1'b0;
        #1;
        check_eq("reset_outs", outs(), 0);
        check_eq("reset_idle", ap_idle, 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Slow producer, fast consumer.
        do_run(4, 3, 3, 0, 0, 300, 1'b0);
        check_eq("t1_push", e_push, 4);
        check_eq("t1_pop", e_pop, 4);
        check_eq("t1_done", e_done, 1);
        check_eq("t1_ready", e_ready, 1);
        check_eq("t1_ready_after_prdy", prdy_at_ready, 4);
        check_eq("t1_ready_lat", ready_cyc - last_prdy_cyc, 1);
        check_eq("t1_done_lat", done_cyc - last_pop_cyc, 1);
        check_eq("t1_viol", viol, 0);
        check_eq("t1_idle", ap_idle, 1);

        // Slow consumer fills the channel; stray ap_start mid-run is ignored.
        do_run(5, 3, 3, 0, 20, 400, 1'b1);
        check_eq("t2_push", e_push, 5);
        check_eq("t2_pop", e_pop, 5);
        check_eq("t2_done", e_done, 1);
        check_eq("t2_max_occ", max_occ, 2);
        check_eq("t2_full_seen", (e_full > 0), 1);
        check_eq("t2_viol", viol, 0);

        // Zero iterations.
        do_run(0, 0, 0, 0, 0, 20, 1'b0);
        check_eq("t3_done", e_done, 1);
        check_eq("t3_ready", e_ready, 1);
        check_eq("t3_done_lat", done_cyc - st_cyc, 1);
        check_eq("t3_ready_lat", ready_cyc - st_cyc, 1);
        check_eq("t3_pstart", e_pstart, 0);
        check_eq("t3_cstart", e_cstart, 0);

        // Ready and done in the same cycle on both sides.
        do_run(3, 0, 0, 0, 0, 100, 1'b0);
        check_eq("t4_push", e_push, 3);
        check_eq("t4_pop", e_pop, 3);
        check_eq("t4_done", e_done, 1);
        check_eq("t4_prdy", e_prdy, 3);
        check_eq("t4_gap_min", gap_min, 2);
        check_eq("t4_gap_max", gap_max, 2);
        check_eq("t4_viol", viol, 0);

        // Asynchronous reset mid-run with one buffer filled, then a clean run.
        launch(4, 1, 1, 0, 50);
        k = 0;
        while (e_push == 0 && k < 100) begin @(posedge clk); #2; k++; end
        check_eq("t5_push_before_rst", e_push, 1);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_outs", outs(), 0);
        check_eq("t5_rst_idle", ap_idle, 1);
`ifdef PINGPONG_CTRL_STALL_CNT_EN
        check_eq("t5_rst_pstall", prod_stall_cnt, 0);
        check_eq("t5_rst_cstall", cons_stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        do_run(2, 1, 1, 1, 1, 100, 1'b0);
        check_eq("t5_push", e_push, 2);
        check_eq("t5_pop", e_pop, 2);
        check_eq("t5_done", e_done, 1);
        check_eq("t5_viol", viol, 0);

`ifdef PINGPONG_CTRL_STALL_CNT_EN
        // Consumer waits on an empty channel: push lands 10 cycles after RUN is entered.
        do_run(1, 3, 4, 0, 0, 100, 1'b0);
        check_eq("t6_done", e_done, 1);
        check_eq("t6_cstall", cons_stall_cnt, 10);
        check_eq("t6_pstall", prod_stall_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

endmodule
